// File: rtl/memarb.sv
// memarb: shares one byte-wide synchronous memory between the instruction-fetch and data ports
module memarb #(
    parameter int IBYTES = 6,
    parameter int AW     = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [AW-1:0]         i_addr,
    output logic [8*IBYTES-1:0]   i_data,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_wide,
    input  logic [AW-1:0]         d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_ready,
    output logic [AW-1:0]         m_addr,
    input  logic [7:0]            m_rdata,
    output logic [7:0]            m_wdata,
    output logic                  m_we,
    output logic                  busy
);
    localparam int CW = $clog2(IBYTES + 2);
    localparam int BW = 8 * IBYTES;

    typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            wide_q, wide_d;
    logic [7:0]      whi_q, whi_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [7:0]      m_wdata_q, m_wdata_d;
    logic            m_we_q, m_we_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   i_data_q, i_data_d;
    logic [15:0]     d_rdata_q, d_rdata_d;
    logic            gnt_data;
    logic [CW-1:0]   nb;
    logic [CW-1:0]   bidx;

    // byte count of the current transaction: full window for fetch, 1 or 2 for data
    assign nb = (state_q == FETCH) ? CW'(IBYTES) : (wide_q ? CW'(2) : CW'(1));

    // sequencer: arbitration in IDLE, byte stepping, capture and reassembly
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        wide_d    = wide_q;
        whi_d     = whi_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = 1'b0;
        buf_d     = buf_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        gnt_data  = d_req && !(i_req && last_q);
        bidx      = cnt_q - CW'(1);
        case (state_q)
            IDLE: if (i_req || d_req) begin
                last_d    = gnt_data;
                cnt_d     = '0;
                wide_d    = d_wide;
                whi_d     = d_wdata[15:8];
                m_addr_d  = gnt_data ? d_addr : i_addr;
                m_we_d    = gnt_data && d_we;
                m_wdata_d = (gnt_data && d_we) ? d_wdata[7:0] : m_wdata_q;
                state_d   = !gnt_data ? FETCH : (d_we ? DWRITE : DREAD);
            end
            FETCH, DREAD: begin
                if (cnt_q != '0) buf_d[{bidx, 3'b000} +: 8] = m_rdata;
                if (cnt_q == nb) begin
                    state_d = DONE;
                    if (state_q == FETCH) i_data_d = buf_d;
                    else d_rdata_d = wide_q ? buf_d[15:0] : {8'h00, buf_d[7:0]};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < nb - CW'(1)) m_addr_d = m_addr_q + AW'(1);
                end
            end
            DWRITE: if (cnt_q < nb - CW'(1)) begin
                m_we_d    = 1'b1;
                m_addr_d  = m_addr_q + AW'(1);
                m_wdata_d = whi_q;
                cnt_d     = cnt_q + CW'(1);
            end else begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            wide_q    <= 1'b0;
            whi_q     <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
            buf_q     <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            wide_q    <= wide_d;
            whi_q     <= whi_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
            buf_q     <= buf_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_we    = m_we_q;
    assign i_ready = (state_q == DONE) && !last_q;
    assign d_ready = (state_q == DONE) && last_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_memarb.sv
// tb_memarb: transaction-level model and directed checks for memarb
module tb_memarb;
    localparam int IB = 6;

    logic clock = 1'b0, reset = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_wide = 1'b0;
    logic [19:0] i_addr = '0, d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [47:0] i_data;
    logic i_ready, d_ready, m_we, busy;
    logic [15:0] d_rdata;
    logic [19:0] m_addr;
    logic [7:0] m_rdata = '0, m_wdata;

    memarb #(.IBYTES(IB), .AW(20)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .m_addr(m_addr), .m_rdata(m_rdata), .m_wdata(m_wdata), .m_we(m_we),
        .busy(busy)
    );

    always #5 clock = ~clock;

    bit [7:0] ram [0:(1<<20)-1];
    bit [7:0] ref_mem [0:(1<<20)-1];

    // synchronous byte memory: read data one cycle after address
    always @(posedge clock) begin
        if (m_we) ram[m_addr] <= m_wdata;
        m_rdata <= ram[m_addr];
    end

    typedef struct {
        logic        busy, chk, we, ir, dr;
        logic [19:0] a;
        logic [7:0]  wd;
        logic [47:0] id;
        logic [15:0] rd;
    } ex_t;

    ex_t q[$];
    logic last_d = 1'b0;
    logic [47:0] m_id = '0;
    logic [15:0] m_rd = '0;
    int cmp = 0, err = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ex_t mk(input logic c, input logic w, input logic [19:0] a,
                               input logic [7:0] wd, input logic ir, input logic dr);
        ex_t e;
        e.busy = 1'b1; e.chk = c; e.we = w; e.a = a; e.wd = wd;
        e.ir = ir; e.dr = dr; e.id = m_id; e.rd = m_rd;
        return e;
    endfunction

    // transaction model: on each grant, queue the expected outputs of every following cycle
    always @(posedge clock or posedge reset) begin
        logic gd;
        logic [19:0] a;
        int n;
        if (reset) begin
            q.delete(); last_d = 1'b0; m_id = '0; m_rd = '0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (i_req || d_req) begin
            gd = d_req && !(i_req && last_d);
            last_d = gd;
            if (!gd) begin
                for (int k = 0; k < IB; k++) q.push_back(mk(1, 0, i_addr + 20'(k), 8'h00, 0, 0));
                q.push_back(mk(1, 0, i_addr + 20'(IB - 1), 8'h00, 0, 0));
                for (int k = 0; k < IB; k++) begin
                    a = i_addr + 20'(k);
                    m_id[8*k +: 8] = ref_mem[a];
                end
                q.push_back(mk(0, 0, '0, 8'h00, 1, 0));
            end else if (d_we) begin
                n = d_wide ? 2 : 1;
                for (int k = 0; k < n; k++) begin
                    a = d_addr + 20'(k);
                    q.push_back(mk(1, 1, a, d_wdata[8*k +: 8], 0, 0));
                    ref_mem[a] = d_wdata[8*k +: 8];
                end
                q.push_back(mk(0, 0, '0, 8'h00, 0, 1));
            end else begin
                n = d_wide ? 2 : 1;
                for (int k = 0; k < n; k++) q.push_back(mk(1, 0, d_addr + 20'(k), 8'h00, 0, 0));
                q.push_back(mk(1, 0, d_addr + 20'(n - 1), 8'h00, 0, 0));
                a = d_addr + 20'(1);
                m_rd = d_wide ? {ref_mem[a], ref_mem[d_addr]} : {8'h00, ref_mem[d_addr]};
                q.push_back(mk(0, 0, '0, 8'h00, 0, 1));
            end
        end
    end

    // compare DUT outputs with the model every cycle
    always @(negedge clock) begin
        ex_t e;
        if (q.size() > 0) e = q[0];
        else begin
            e.busy = 0; e.chk = 0; e.we = 0; e.ir = 0; e.dr = 0;
            e.a = '0; e.wd = '0; e.id = m_id; e.rd = m_rd;
        end
        chk("busy", 48'(busy), 48'(e.busy));
        chk("m_we", 48'(m_we), 48'(e.we));
        chk("i_ready", 48'(i_ready), 48'(e.ir));
        chk("d_ready", 48'(d_ready), 48'(e.dr));
        chk("i_data", i_data, e.id);
        chk("d_rdata", 48'(d_rdata), 48'(e.rd));
        if (e.chk) chk("m_addr", 48'(m_addr), 48'(e.a));
        if (e.we) chk("m_wdata", 48'(m_wdata), 48'(e.wd));
    end

    task automatic poke(input logic [19:0] a, input logic [7:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic wait_rdy(input bit isf, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(isf ? i_ready : d_ready) && n < 200);
        if (!(isf ? i_ready : d_ready)) chk({nm, "_timeout"}, 48'(0), 48'(1));
    endtask

    task automatic fetch(input logic [19:0] a, output int n);
        @(negedge clock);
        i_req = 1; i_addr = a;
        wait_rdy(1, "fetch", n);
        i_req = 0;
    endtask

    task automatic data(input logic we, input logic wide, input logic [19:0] a,
                        input logic [15:0] wd, output int n);
        @(negedge clock);
        d_req = 1; d_we = we; d_wide = wide; d_addr = a; d_wdata = wd;
        wait_rdy(0, "data", n);
        d_req = 0;
    endtask

    initial begin
        int n, seq, dcnt;
        for (int k = 0; k < 6; k++) begin
            poke(20'h01230 + 20'(k), 8'(k + 1));
            poke(20'hFFFFD + 20'(k), 8'(8'hA1 + k));
        end
        repeat (3) @(negedge clock);
        chk("rst_busy", 48'(busy), 48'(0));
        chk("rst_m_addr", 48'(m_addr), 48'(0));
        chk("rst_i_data", i_data, 48'(0));
        reset = 0;

        fetch(20'h01230, n);
        chk("fetch_lat", 48'(n), 48'(8));
        chk("fetch_data", i_data, 48'h060504030201);

        data(1, 1, 20'h20000, 16'hBEEF, n);
        chk("wr16_lo", 48'(ram[20'h20000]), 48'hEF);
        chk("wr16_hi", 48'(ram[20'h20001]), 48'hBE);
        data(0, 1, 20'h20000, 16'h0000, n);
        chk("rd16", 48'(d_rdata), 48'hBEEF);
        data(0, 0, 20'h20001, 16'h0000, n);
        chk("rd8", 48'(d_rdata), 48'h00BE);

        data(1, 0, 20'h00400, 16'h12AB, n);
        chk("wr8_lat", 48'(n), 48'(2));
        chk("wr8_mem", 48'(ram[20'h00400]), 48'hAB);
        chk("wr8_next", 48'(ram[20'h00401]), 48'h00);
        chk("wr8_rdata", 48'(d_rdata), 48'h00BE);

        fetch(20'hFFFFD, n);
        chk("wrap_data", i_data, 48'hA6A5A4A3A2A1);

        @(negedge clock);
        i_req = 1; i_addr = 20'h01230;
        d_req = 1; d_we = 0; d_wide = 1; d_addr = 20'h20000;
        seq = 0; dcnt = 0;
        for (int c = 0; c < 100 && dcnt < 2; c++) begin
            @(negedge clock);
            if (d_ready) begin
                seq = seq * 4 + 1; dcnt++;
                if (dcnt == 2) d_req = 0;
            end
            if (i_ready) begin
                seq = seq * 4 + 2; i_req = 0;
            end
        end
        chk("arb_order", 48'(seq), 48'(25));
        chk("arb_rdata", 48'(d_rdata), 48'hBEEF);

        @(negedge clock);
        i_req = 1; i_addr = 20'h01230;
        repeat (4) @(negedge clock);
        #1 reset = 1;
        #1;
        chk("mid_busy", 48'(busy), 48'(0));
        chk("mid_i_ready", 48'(i_ready), 48'(0));
        chk("mid_m_addr", 48'(m_addr), 48'(0));
        chk("mid_i_data", i_data, 48'(0));
        chk("mid_d_rdata", 48'(d_rdata), 48'(0));
        @(negedge clock);
        reset = 0;
        wait_rdy(1, "restart", n);
        i_req = 0;
        chk("restart_lat", 48'(n), 48'(8));
        chk("restart_data", i_data, 48'h060504030201);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/memarb.md
Name: memarb

Overview:
- Sequencer/arbiter that shares one byte-wide synchronous memory between the CPU instruction-fetch port (48-bit instruction window) and the CPU data port (8/16-bit read/write).
- Sits between the cpu core and the external SRAM/BRAM.
- Splits each request into byte cycles, reassembles little-endian results and returns a one-cycle ready pulse per requester.
- Arbitration: data has priority, with anti-starvation alternation for fetch.

Parameters:
- IBYTES, 6: bytes per instruction fetch; i_data width is 8*IBYTES.
- AW, 20: physical address width; addresses wrap modulo 2^AW.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ready
- i_addr  in  AW  fetch linear address (cs*16+ip)
- i_data  out  8*IBYTES  fetched bytes; byte k at bits [8k+7:8k]
- i_ready  out  1  one-cycle pulse, i_data valid this cycle and held until next fetch completes
- d_req  in  1  data request, level, held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_wide  in  1  1 = 16-bit, 0 = 8-bit
- d_addr  in  AW  data linear address (seg*16+ea)
- d_wdata  in  16  write data; low byte first
- d_rdata  out  16  read result; 8-bit reads zero-extended
- d_ready  out  1  one-cycle completion pulse
- m_addr  out  AW  memory byte address (registered)
- m_rdata  in  8  memory read data, valid one cycle after m_addr
- m_wdata  out  8  memory write byte (registered)
- m_we  out  1  memory write strobe (registered)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE, m_addr=0, m_wdata=0, m_we=0, i_ready=0, d_ready=0, i_data=0, d_rdata=0, byte counter=0, last_grant=FETCH. Any in-flight transaction is abandoned with no ready pulse. Writes already issued are not undone.
- States: IDLE, FETCH, DREAD, DWRITE, DONE.
- Requests are sampled only in IDLE. Inputs i_addr, d_addr, d_we, d_wide and d_wdata are latched on grant; later changes have no effect.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant DATA, unless last_grant==DATA, in which case grant FETCH.
  - last_grant is updated on every grant.
- FETCH:
  - Cycles F0..F(IBYTES-1) drive m_addr = base+k.
  - Cycle F(IBYTES) is a drain cycle; m_addr holds its last value.
  - Byte k is captured from m_rdata in cycle F(k+1).
  - Then DONE with i_ready=1.
  - IBYTES=6 gives 7 FETCH cycles, with i_ready asserted 8 cycles after the granting edge.
- DREAD:
  - One address cycle per byte (2 if d_wide, else 1), plus one drain cycle. Capture is the same as FETCH.
  - Then DONE with d_ready=1.
  - 8-bit read: d_rdata = {8'h00, byte0}.
- DWRITE:
  - One cycle per byte with m_we=1, m_addr=base+k and m_wdata = low byte, then high byte.
  - No drain cycle; then DONE with d_ready=1, m_we=0.
- DONE:
  - Exactly one cycle; the matching ready is high and requests are ignored.
  - Next state is IDLE.
  - Requester must drop or replace its req by the edge ending DONE.
  - Back-to-back transactions therefore have one IDLE cycle between them.
- m_we is 0 in every state except DWRITE.
- Address increment wraps: base 0xFFFFF, byte 1 goes to address 0x00000.
- Hold rules: d_rdata holds until the next data read completes; i_data holds until the next fetch completes. Writes do not alter d_rdata.
- busy=0 only in IDLE.

Test Plan:
- Fetch only: mem[0x01230..0x01235]=01..06, i_req=1, i_addr=0x01230 -> m_addr steps 0x01230..0x01235, i_ready single pulse 8 cycles after grant, i_data=48'h060504030201.
- 16-bit write then read: d_we=1, d_wide=1, d_addr=0x20000, d_wdata=16'hBEEF -> m_we on 2 cycles, bytes EF@0x20000 then BE@0x20001, d_ready pulse. Read back -> d_rdata=16'hBEEF. 8-bit read of 0x20001 -> d_rdata=16'h00BE.
- Simultaneous requests: i_req and d_req both held from IDLE with last_grant=FETCH -> data served first. The fetch is granted next even though d_req is re-asserted immediately; the data request is served after the fetch.
- Wrap-around: fetch at i_addr=0xFFFFD -> m_addr sequence FFFFD, FFFFE, FFFFF, 00000, 00001, 00002.
- Reset mid-fetch: assert reset during cycle F3 -> all outputs zero immediately, no i_ready pulse, state IDLE. After release with i_req held, the fetch restarts from F0.
- Byte write: d_wide=0, d_addr=0x00400, d_wdata=16'h12AB -> exactly one m_we cycle writing AB to 0x00400, d_ready 2 cycles after grant, d_rdata unchanged.
